// File: rtl/vram_fill_ctrl_pkg.sv
// Shared definitions for the VRAM fill controller and its neighbours
// (VGA timing, VRAM): screen geometry defaults, address/colour widths, FSM states.
package vram_fill_ctrl_pkg;

    localparam int unsigned H_RES_DEF   = 640;
    localparam int unsigned V_RES_DEF   = 480;
    localparam int unsigned COL_W       = 10;
    localparam int unsigned ROW_W       = 9;
    localparam int unsigned COLOR_W_DEF = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

endpackage

// File: rtl/vram_fill_ctrl_if.sv
// Command channel, VRAM write port and status of the fill controller.
// master = command/arbiter side, slave = the fill controller itself.
interface vram_fill_ctrl_if
    import vram_fill_ctrl_pkg::*;
#(
    parameter int COLOR_W = COLOR_W_DEF
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [COL_W-1:0]   cmd_x0;
    logic [COL_W-1:0]   cmd_x1;
    logic [ROW_W-1:0]   cmd_y0;
    logic [ROW_W-1:0]   cmd_y1;
    logic [COLOR_W-1:0] cmd_color;
    logic               abort;
    logic               wr_allow;
    logic               we;
    logic [ROW_W-1:0]   w_row;
    logic [COL_W-1:0]   w_col;
    logic [COLOR_W-1:0] w_data;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, abort, wr_allow,
        input  cmd_ready, we, w_row, w_col, w_data, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, abort, wr_allow,
        output cmd_ready, we, w_row, w_col, w_data, busy, done, err
    );

endinterface

// File: rtl/vram_fill_ctrl_fill_addr_gen.sv
// Raster-order row/column counter for a rectangle fill: loads the start corner
// and bounds, advances one pixel per step, holds while step is low.
module fill_addr_gen
    import vram_fill_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [COL_W-1:0] x0,
    input  logic [COL_W-1:0] x1,
    input  logic [ROW_W-1:0] y0,
    input  logic [ROW_W-1:0] y1,
    input  logic             step,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last
);
    logic [COL_W-1:0] x0_q;
    logic [COL_W-1:0] x1_q;
    logic [ROW_W-1:0] y1_q;

    // Load bounds/start on command, then walk columns and wrap to the next row.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row  <= '0;
            col  <= '0;
            x0_q <= '0;
            x1_q <= '0;
            y1_q <= '0;
        end else if (load) begin
            row  <= y0;
            col  <= x0;
            x0_q <= x0;
            x1_q <= x1;
            y1_q <= y1;
        end else if (step) begin
            if (col != x1_q) begin
                col <= col + 1'b1;
            end else begin
                col <= x0_q;
                row <= row + 1'b1;
            end
        end
    end

    // Current address is the final pixel of the rectangle.
    always_comb begin
        last = (row == y1_q) && (col == x1_q);
    end

endmodule

// File: rtl/vram_fill_ctrl.sv
// Rectangle fill controller: accepts a fill command, validates and clips it
// to the screen, then writes the colour to every pixel in raster order
// whenever the VRAM write port is granted.
module vram_fill_ctrl
    import vram_fill_ctrl_pkg::*;
#(
    parameter int H_RES   = H_RES_DEF,
    parameter int V_RES   = V_RES_DEF,
    parameter int COLOR_W = COLOR_W_DEF
)(
    input  logic           clk,
    input  logic           rstn,
    vram_fill_ctrl_if.slave bus
);
    localparam logic [COL_W-1:0] X_MAX = COL_W'(H_RES - 1);
    localparam logic [ROW_W-1:0] Y_MAX = ROW_W'(V_RES - 1);

    fill_state_t        state;
    fill_state_t        state_nxt;
    logic               xfer;
    logic               cmd_bad;
    logic               load;
    logic               we_int;
    logic               last;
    logic               err_q;
    logic [COLOR_W-1:0] color_q;
    logic [COL_W-1:0]   x1_clip;
    logic [ROW_W-1:0]   y1_clip;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;

    // Command handshake, validity check and clipping of the far corner.
    always_comb begin
        xfer    = bus.cmd_valid && (state == IDLE);
        cmd_bad = (bus.cmd_x0 > bus.cmd_x1) || (bus.cmd_y0 > bus.cmd_y1) ||
                  (int'(bus.cmd_x0) >= H_RES) || (int'(bus.cmd_y0) >= V_RES);
        load    = xfer && !cmd_bad;
        x1_clip = (int'(bus.cmd_x1) > H_RES - 1) ? X_MAX : bus.cmd_x1;
        y1_clip = (int'(bus.cmd_y1) > V_RES - 1) ? Y_MAX : bus.cmd_y1;
        we_int  = (state == FILL) && bus.wr_allow && !bus.abort;
    end

    fill_addr_gen u_addr (
        .clk  (clk),
        .rstn (rstn),
        .load (load),
        .x0   (bus.cmd_x0),
        .x1   (x1_clip),
        .y0   (bus.cmd_y0),
        .y1   (y1_clip),
        .step (we_int),
        .row  (row),
        .col  (col),
        .last (last)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Fill colour capture and one-cycle rejection pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            color_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= xfer && cmd_bad;
            if (load) begin
                color_q <= bus.cmd_color;
            end
        end
    end

    // Next-state logic; abort has priority over a granted write.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (load) state_nxt = FILL;
            FILL: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (bus.wr_allow && last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state plus the registered address/data.
    always_comb begin
        bus.cmd_ready = (state == IDLE);
        bus.busy      = (state != IDLE);
        bus.done      = (state == DONE);
        bus.err       = err_q;
        bus.we        = we_int;
        bus.w_row     = row;
        bus.w_col     = col;
        bus.w_data    = color_q;
    end

endmodule
